// File: rtl/dcache_ctrl_if.sv
// Bundle of core-side, array-side and memory-side signals of the data-cache miss controller.
// The master modport is the controller; the slave modport is the core/array/memory environment.
interface dcache_ctrl_if #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 5,
    parameter int BLOCK_W  = 128
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                     cpu_req;
    logic                     cpu_wen;
    logic [1:0]               cpu_size;
    logic [ADDR_W-1:0]        cpu_addr;
    logic [31:0]              cpu_wdata;
    logic [31:0]              cpu_rdata;
    logic                     cpu_stall;
    logic                     cpu_misalign;

    logic                     sram_en;
    logic                     sram_wen;
    logic                     sram_memWen;
    logic [BLOCK_W/8-1:0]     sram_bytes;
    logic [TAG_W+INDEX_W-1:0] sram_blockAddr;
    logic [BLOCK_W-1:0]       sram_dataIn;
    logic                     sram_hit;
    logic                     sram_dirty;
    logic [BLOCK_W-1:0]       sram_dataOut;
    logic [TAG_W-1:0]         sram_victim_tag;
    logic [BLOCK_W-1:0]       sram_victim_data;

    logic                     mem_req;
    logic                     mem_wen;
    logic [ADDR_W-1:0]        mem_addr;
    logic [BLOCK_W-1:0]       mem_wdata;
    logic [BLOCK_W-1:0]       mem_rdata;
    logic                     mem_ready;

    logic [15:0]              cnt_hit;
    logic [15:0]              cnt_miss;
    logic [15:0]              cnt_wb;

    modport master (
        input  cpu_req, cpu_wen, cpu_size, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_misalign,
        output sram_en, sram_wen, sram_memWen, sram_bytes, sram_blockAddr, sram_dataIn,
        input  sram_hit, sram_dirty, sram_dataOut, sram_victim_tag, sram_victim_data,
        output mem_req, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output cnt_hit, cnt_miss, cnt_wb
    );

    modport slave (
        output cpu_req, cpu_wen, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_misalign,
        input  sram_en, sram_wen, sram_memWen, sram_bytes, sram_blockAddr, sram_dataIn,
        output sram_hit, sram_dirty, sram_dataOut, sram_victim_tag, sram_victim_data,
        input  mem_req, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  cnt_hit, cnt_miss, cnt_wb
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Miss-handling controller for the 2-way 1 KB data cache: same-cycle hits, dirty writeback,
// block refill and replay of the held core access.
//   state  | meaning
//   IDLE   | serve hits; detect misses and misaligned accesses
//   WB     | write the captured dirty victim back to memory
//   REFILL | fetch the missing block from memory
//   FILL   | write the refilled block into the array, then replay
module dcache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 5,
    parameter int BLOCK_W  = 128
) (
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.master bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LANES = BLOCK_W / 8;

    typedef enum logic [1:0] {IDLE, WB, REFILL, FILL} state_t;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] line_q, line_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic               replay_q;
    logic [15:0]        cnt_hit_q, cnt_hit_d;
    logic [15:0]        cnt_miss_q, cnt_miss_d;
    logic [15:0]        cnt_wb_q, cnt_wb_d;

    logic [ADDR_W-OFFSET_W-1:0] blk;
    logic [OFFSET_W-1:0]        off;
    logic                       misaligned;
    logic [LANES-1:0]           lanes;
    logic [BLOCK_W-1:0]         store_data;
    logic [31:0]                load_word;

    assign blk       = bus.cpu_addr[ADDR_W-1:OFFSET_W];
    assign off       = bus.cpu_addr[OFFSET_W-1:0];
    assign load_word = bus.sram_dataOut[{off[3:2], 5'b0} +: 32];

    always_comb begin
        misaligned = 1'b0;
        lanes      = '0;
        store_data = '0;
        case (bus.cpu_size)
            2'd0: begin
                lanes      = LANES'(1) << off;
                store_data = {LANES{bus.cpu_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = off[0];
                lanes      = LANES'(3) << off;
                store_data = {(LANES/2){bus.cpu_wdata[15:0]}};
            end
            2'd2: begin
                misaligned = |off[1:0];
                lanes      = LANES'(15) << {off[3:2], 2'b00};
                store_data = {(LANES/4){bus.cpu_wdata}};
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        vtag_d     = vtag_q;
        cnt_hit_d  = cnt_hit_q;
        cnt_miss_d = cnt_miss_q;
        cnt_wb_d   = cnt_wb_q;

        bus.cpu_rdata      = '0;
        bus.cpu_stall      = 1'b0;
        bus.cpu_misalign   = 1'b0;
        bus.sram_en        = 1'b0;
        bus.sram_wen       = 1'b0;
        bus.sram_memWen    = 1'b0;
        bus.sram_bytes     = '0;
        bus.sram_blockAddr = '0;
        bus.sram_dataIn    = '0;
        bus.mem_req        = 1'b0;
        bus.mem_wen        = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;

        // Outputs are forced quiet while reset is held, whatever the core drives.
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        if (misaligned) begin
                            bus.cpu_misalign = 1'b1;
                        end else begin
                            bus.sram_en        = 1'b1;
                            bus.sram_blockAddr = blk;
                            if (bus.sram_hit) begin
                                if (bus.cpu_wen) begin
                                    bus.sram_wen    = 1'b1;
                                    bus.sram_bytes  = lanes;
                                    bus.sram_dataIn = store_data;
                                end else begin
                                    bus.cpu_rdata = load_word;
                                end
                                // The replayed access was already counted as a miss.
                                if (!replay_q) cnt_hit_d = cnt_hit_q + 16'd1;
                            end else begin
                                bus.cpu_stall = 1'b1;
                                if (!replay_q) cnt_miss_d = cnt_miss_q + 16'd1;
                                if (bus.sram_dirty) begin
                                    vtag_d  = bus.sram_victim_tag;
                                    line_d  = bus.sram_victim_data;
                                    state_d = WB;
                                end else begin
                                    state_d = REFILL;
                                end
                            end
                        end
                    end
                end
                WB: begin
                    bus.cpu_stall = 1'b1;
                    bus.mem_req   = 1'b1;
                    bus.mem_wen   = 1'b1;
                    bus.mem_addr  = {vtag_q, blk[INDEX_W-1:0], {OFFSET_W{1'b0}}};
                    bus.mem_wdata = line_q;
                    if (bus.mem_ready) begin
                        cnt_wb_d = cnt_wb_q + 16'd1;
                        state_d  = REFILL;
                    end
                end
                REFILL: begin
                    bus.cpu_stall = 1'b1;
                    bus.mem_req   = 1'b1;
                    bus.mem_addr  = {blk, {OFFSET_W{1'b0}}};
                    if (bus.mem_ready) begin
                        line_d  = bus.mem_rdata;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    bus.cpu_stall      = 1'b1;
                    bus.sram_en        = 1'b1;
                    bus.sram_wen       = 1'b1;
                    bus.sram_memWen    = 1'b1;
                    bus.sram_bytes     = '1;
                    bus.sram_blockAddr = blk;
                    bus.sram_dataIn    = line_q;
                    state_d            = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            line_q     <= '0;
            vtag_q     <= '0;
            replay_q   <= 1'b0;
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
            cnt_wb_q   <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            vtag_q     <= vtag_d;
            replay_q   <= (state_q == FILL);
            cnt_hit_q  <= cnt_hit_d;
            cnt_miss_q <= cnt_miss_d;
            cnt_wb_q   <= cnt_wb_d;
        end
    end

    assign bus.cnt_hit  = cnt_hit_q;
    assign bus.cnt_miss = cnt_miss_q;
    assign bus.cnt_wb   = cnt_wb_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural 2-way array and main memory around the controller,
// with a flat byte-addressed reference memory and event counts as the expected behaviour.
module tb_dcache_ctrl;
    localparam int TAG_W = 23;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dcache_ctrl_if ifc ();
    dcache_ctrl dut (.clk(clk), .rst(rst), .bus(ifc.master));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Two-way array model with an MRU bit per set.
    logic [1:0][31:0]   vld = '0;
    logic [1:0][31:0]   drt = '0;
    logic [31:0]        mru = '0;
    logic [TAG_W-1:0]   tg  [2][32];
    logic [127:0]       dat [2][32];
    logic [4:0]         s_set;
    logic [TAG_W-1:0]   s_tag;
    logic               h0, h1, vw;
    logic [127:0]       merged;
    int                 n_arr_wr = 0;
    logic [15:0]        last_fill_bytes = '0;

    always_comb begin
        s_set = ifc.sram_blockAddr[4:0];
        s_tag = ifc.sram_blockAddr[27:5];
        h0 = vld[0][s_set] && (tg[0][s_set] == s_tag);
        h1 = vld[1][s_set] && (tg[1][s_set] == s_tag);
        if (!vld[0][s_set])      vw = 1'b0;
        else if (!vld[1][s_set]) vw = 1'b1;
        else                     vw = ~mru[s_set];
        ifc.sram_hit         = ifc.sram_en && (h0 || h1);
        ifc.sram_dataOut     = h0 ? dat[0][s_set] : (h1 ? dat[1][s_set] : '0);
        ifc.sram_dirty       = vld[vw][s_set] && drt[vw][s_set];
        ifc.sram_victim_tag  = tg[vw][s_set];
        ifc.sram_victim_data = dat[vw][s_set];
        merged = ifc.sram_dataOut;
        for (int i = 0; i < 16; i++)
            if (ifc.sram_bytes[i]) merged[8*i +: 8] = ifc.sram_dataIn[8*i +: 8];
    end

    always @(posedge clk) begin
        if (ifc.sram_en && ifc.sram_wen) begin
            n_arr_wr <= n_arr_wr + 1;
            if (ifc.sram_memWen) begin
                last_fill_bytes   <= ifc.sram_bytes;
                dat[vw][s_set]    <= ifc.sram_dataIn;
                tg[vw][s_set]     <= s_tag;
                vld[vw][s_set]    <= 1'b1;
                drt[vw][s_set]    <= 1'b0;
                mru[s_set]        <= vw;
            end else if (h0 || h1) begin
                dat[!h0][s_set]   <= merged;
                drt[!h0][s_set]   <= 1'b1;
                mru[s_set]        <= !h0;
            end
        end else if (ifc.sram_hit) begin
            mru[s_set] <= !h0;
        end
    end

    // Main memory model and responder.
    logic [127:0] mem_m [int unsigned];
    logic [7:0]   ref_b [int unsigned];
    int           mem_lat = 0;
    int           n_ready = 0;
    int           n_wb_seen = 0;
    logic         r_act = 1'b0;
    int           r_rem = 0;
    logic         r_wen = 1'b0;
    logic [31:0]  r_addr = '0;
    logic [127:0] r_wdata = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [31:0]  last_rd_addr = '0;
    logic [127:0] last_wb_data = '0;

    function automatic logic [127:0] init_blk(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a * 3 + 32'h11, ~a, a + 32'h0101_0101};
    endfunction

    function automatic logic [127:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return init_blk(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [127:0] b;
        if (ref_b.exists(a)) return ref_b[a];
        b = init_blk({a[31:4], 4'h0});
        return b[8*a[3:0] +: 8];
    endfunction

    always @(negedge clk) begin
        ifc.mem_ready = 1'b0;
        if (!r_act && ifc.mem_req) begin
            r_act   = 1'b1;
            r_rem   = mem_lat;
            r_wen   = ifc.mem_wen;
            r_addr  = ifc.mem_addr;
            r_wdata = ifc.mem_wdata;
        end
        if (r_act) begin
            if (r_rem == 0) begin
                r_act = 1'b0;
                ifc.mem_ready = 1'b1;
                n_ready++;
                if (r_wen) begin
                    mem_m[r_addr] = r_wdata;
                    last_wb_addr  = r_addr;
                    last_wb_data  = r_wdata;
                    n_wb_seen++;
                end else begin
                    ifc.mem_rdata = mem_rd(r_addr);
                    last_rd_addr  = r_addr;
                end
            end else begin
                r_rem--;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int           e_hit = 0, e_miss = 0, e_wb = 0;
    int           a_stall;
    logic [31:0]  a_rdata;
    logic         a_mis, a_swen;
    logic [15:0]  a_bytes;
    logic [127:0] a_din;

    task automatic access(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
        ifc.cpu_req   = 1'b1;
        ifc.cpu_wen   = wen;
        ifc.cpu_size  = size;
        ifc.cpu_addr  = addr;
        ifc.cpu_wdata = wdata;
        a_stall = 0;
        @(negedge clk);
        while (ifc.cpu_stall && a_stall < 60) begin
            a_stall++;
            @(negedge clk);
        end
        a_rdata = ifc.cpu_rdata;
        a_mis   = ifc.cpu_misalign;
        a_swen  = ifc.sram_wen;
        a_bytes = ifc.sram_bytes;
        a_din   = ifc.sram_dataIn;
        @(posedge clk);
        #1;
        ifc.cpu_req = 1'b0;
        ifc.cpu_wen = 1'b0;
    endtask

    task automatic chk_counters();
        chk("cnt_hit",  128'(ifc.cnt_hit),  128'(16'(e_hit)));
        chk("cnt_miss", 128'(ifc.cnt_miss), 128'(16'(e_miss)));
        chk("cnt_wb",   128'(ifc.cnt_wb),   128'(16'(e_wb)));
    endtask

    task automatic op(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input int lat);
        int nbytes, exp_stall, wb_before, start;
        logic mis, pres, vdirty, vwx;
        logic [4:0] st;
        logic [31:0] wa, exp_word, exp_wb_a;
        logic [127:0] exp_wb_d;
        logic [15:0] exp_lanes;
        nbytes = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
        mis    = (size == 2'd3) || ((addr % nbytes) != 0);
        st     = addr[8:4];
        pres   = (vld[0][st] && tg[0][st] == addr[31:9]) || (vld[1][st] && tg[1][st] == addr[31:9]);
        vwx    = !vld[0][st] ? 1'b0 : (!vld[1][st] ? 1'b1 : !mru[st]);
        vdirty = vld[vwx][st] && drt[vwx][st];
        exp_wb_a = {tg[vwx][st], st, 4'h0};
        exp_wb_d = dat[vwx][st];
        wa = {addr[31:2], 2'b00};
        exp_word = {ref_rd(wa + 3), ref_rd(wa + 2), ref_rd(wa + 1), ref_rd(wa)};
        exp_stall = (mis || pres) ? 0 : (vdirty ? 4 + 2 * lat : 3 + lat);
        if (!mis) begin
            if (pres) e_hit++;
            else begin
                e_miss++;
                if (vdirty) e_wb++;
            end
        end
        wb_before = n_wb_seen;
        mem_lat = lat;
        access(wen, size, addr, wdata);
        chk("stall_cycles", 128'(a_stall), 128'(exp_stall));
        chk("misalign", 128'(a_mis), 128'(mis));
        chk("rdata", 128'(a_rdata), (!mis && !wen) ? 128'(exp_word) : 128'(0));
        chk("wb_issued", 128'(n_wb_seen - wb_before), 128'(!mis && !pres && vdirty));
        if (!mis && !pres) chk("refill_addr", 128'(last_rd_addr), 128'({addr[31:4], 4'h0}));
        if (!mis && !pres && vdirty) begin
            chk("wb_addr", 128'(last_wb_addr), 128'(exp_wb_a));
            chk("wb_data", last_wb_data, exp_wb_d);
        end
        if (mis) chk("misalign_no_write", 128'(a_swen), 128'(0));
        if (!mis && wen) begin
            start = int'(addr[3:0]);
            exp_lanes = '0;
            for (int i = 0; i < nbytes; i++) exp_lanes[start + i] = 1'b1;
            chk("store_lanes", 128'(a_bytes), 128'(exp_lanes));
            for (int i = 0; i < nbytes; i++) begin
                chk("store_lane_data", 128'(a_din[8*(start+i) +: 8]), 128'(wdata[8*i +: 8]));
                ref_b[addr + i] = wdata[8*i +: 8];
            end
        end
        chk_counters();
    endtask

    task automatic preload(input logic [31:0] baddr, input logic [127:0] d);
        mem_m[baddr] = d;
        for (int i = 0; i < 16; i++) ref_b[baddr + i] = d[8*i +: 8];
    endtask

    initial begin
        int wr0, rd0;
        logic [31:0] ra;
        logic [1:0]  rs;
        ifc.cpu_req   = 1'b1;
        ifc.cpu_wen   = 1'b0;
        ifc.cpu_size  = 2'd2;
        ifc.cpu_addr  = 32'h100;
        ifc.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall",    128'(ifc.cpu_stall),    128'(0));
        chk("rst_mem_req",  128'(ifc.mem_req),      128'(0));
        chk("rst_sram_en",  128'(ifc.sram_en),      128'(0));
        chk("rst_rdata",    128'(ifc.cpu_rdata),    128'(0));
        chk("rst_misalign", 128'(ifc.cpu_misalign), 128'(0));
        chk_counters();
        @(posedge clk);
        #1;
        ifc.cpu_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        preload(32'h100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        op(1'b0, 2'd2, 32'h100, 32'h0, 1);
        op(1'b0, 2'd2, 32'h108, 32'h0, 0);
        chk("hit_load_word", 128'(a_rdata), 128'(32'hCCCCCCCC));
        chk("hit_cnt_one",   128'(ifc.cnt_hit), 128'(1));

        op(1'b0, 2'd2, 32'h200, 32'h0, 2);
        chk("clean_miss_stall", 128'(a_stall), 128'(5));
        chk("fill_bytes", 128'(last_fill_bytes), 128'(16'hFFFF));

        op(1'b1, 2'd0, 32'h203, 32'h0000_00A5, 0);
        chk("byte_store_lanes", 128'(a_bytes), 128'(16'h0008));
        chk("byte_store_lane3", 128'(a_din[31:24]), 128'(8'hA5));
        op(1'b0, 2'd2, 32'h200, 32'h0, 0);
        chk("byte_store_readback", 128'(a_rdata[31:24]), 128'(8'hA5));

        op(1'b0, 2'd2, 32'h000, 32'h0, 1);
        op(1'b1, 2'd2, 32'h004, 32'h1234_5678, 0);
        op(1'b1, 2'd1, 32'h20E, 32'h0000_BEEF, 0);
        op(1'b0, 2'd2, 32'h400, 32'h0, 1);
        chk("dirty_miss_wb_cnt", 128'(ifc.cnt_wb), 128'(1));
        op(1'b0, 2'd2, 32'h200, 32'h0, 0);

        op(1'b1, 2'd1, 32'h101, 32'h0000_FFFF, 0);
        op(1'b0, 2'd3, 32'h100, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'd1) ra[0] = 1'b0;
                if (rs == 2'd2) ra[1:0] = 2'b00;
            end
            op(1'($urandom_range(0, 1)), rs, ra, $urandom, $urandom_range(0, 3));
        end

        mem_lat = 6;
        ifc.cpu_req   = 1'b1;
        ifc.cpu_wen   = 1'b0;
        ifc.cpu_size  = 2'd2;
        ifc.cpu_addr  = 32'hFFFF_FFF0;
        repeat (3) @(negedge clk);
        chk("refill_req_active", 128'(ifc.mem_req), 128'(1));
        rst = 1'b0;
        #1;
        chk("rst_drops_mem_req", 128'(ifc.mem_req),   128'(0));
        chk("rst_mid_stall",     128'(ifc.cpu_stall), 128'(0));
        ifc.cpu_req = 1'b0;
        e_hit = 0;
        e_miss = 0;
        e_wb = 0;
        chk_counters();
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr0 = n_arr_wr;
        rd0 = n_ready;
        repeat (10) @(negedge clk);
        chk("stray_ready_seen",   128'(n_ready - rd0),  128'(1));
        chk("stray_no_arr_write", 128'(n_arr_wr - wr0), 128'(0));
        chk("post_rst_mem_req",   128'(ifc.mem_req),    128'(0));
        chk("post_rst_stall",     128'(ifc.cpu_stall),  128'(0));
        chk_counters();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
